// File: rtl/seq_div_8by4.sv
// Sequential 8-bit by 4-bit unsigned restoring divider, one quotient bit per cycle.
// Define DIV_ZERO_SHORTCUT_EN to finish a divide-by-zero in one cycle instead of eight.
module seq_div_8by4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] dvd_q, dvd_d;
  logic [3:0] dvs_q, dvs_d;
  logic [4:0] prem_q, prem_d;
  logic [7:0] pquo_q, pquo_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] quo_q, quo_d;
  logic [3:0] rem_q, rem_d;
  logic       dbz_q, dbz_d;

  logic [5:0] trial;
  logic [4:0] diff;
  logic       qbit;
  logic [4:0] step_rem;
  logic [7:0] step_quo;

  // One restoring step; trial keeps the carried-out bit so the compare is exact.
  always_comb begin
    trial    = {prem_q, dvd_q[7]};
    qbit     = (trial >= {2'b00, dvs_q});
    diff     = trial[4:0] - {1'b0, dvs_q};
    step_rem = qbit ? diff : trial[4:0];
    step_quo = {pquo_q[6:0], qbit};
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    pquo_d  = pquo_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          prem_d  = 5'd0;
          pquo_d  = 8'd0;
          cnt_d   = 3'd0;
          state_d = S_RUN;
`ifdef DIV_ZERO_SHORTCUT_EN
          if (divisor == 4'd0) begin
            quo_d   = 8'hFF;
            rem_d   = dividend[3:0];
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_RUN: begin
        dvd_d  = {dvd_q[6:0], 1'b0};
        prem_d = step_rem;
        pquo_d = step_quo;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          quo_d   = step_quo;
          rem_d   = step_rem[3:0];
          dbz_d   = (dvs_q == 4'd0);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= 8'd0;
      dvs_q   <= 4'd0;
      prem_q  <= 5'd0;
      pquo_q  <= 8'd0;
      cnt_q   <= 3'd0;
      quo_q   <= 8'd0;
      rem_q   <= 4'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      pquo_q  <= pquo_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_8by4.sv
// Self-checking bench for seq_div_8by4: transaction-level reference model plus directed vectors.
module tb_seq_div_8by4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

`ifdef DIV_ZERO_SHORTCUT_EN
  localparam bit SHORT = 1'b1;
`else
  localparam bit SHORT = 1'b0;
`endif

  seq_div_8by4 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: cycles remaining until the division is over, and committed results.
  int         m_cnt = 0;
  logic [7:0] m_q = 8'd0, p_q = 8'd0;
  logic [3:0] m_r = 4'd0, p_r = 4'd0;
  logic       m_z = 1'b0, p_z = 1'b0;
  int         exp_dones = 0;
  int         dut_dones = 0;
  bit         armed = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0;
      m_q = 8'd0; m_r = 4'd0; m_z = 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        if (divisor == 4'd0) begin
          p_q = 8'hFF; p_r = dividend[3:0]; p_z = 1'b1;
        end else begin
          p_q = 8'(int'(dividend) / int'(divisor));
          p_r = 4'(int'(dividend) % int'(divisor));
          p_z = 1'b0;
        end
        m_cnt = (SHORT && divisor == 4'd0) ? 1 : 9;
        if (m_cnt == 1) begin
          m_q = p_q; m_r = p_r; m_z = p_z; exp_dones++;
        end
      end
    end else begin
      m_cnt--;
      if (m_cnt == 1) begin
        m_q = p_q; m_r = p_r; m_z = p_z; exp_dones++;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("busy", int'(busy), int'(m_cnt != 0));
      chk("done", int'(done), int'(m_cnt == 1));
      chk("quotient", int'(quotient), int'(m_q));
      chk("remainder", int'(remainder), int'(m_r));
      chk("div_by_zero", int'(div_by_zero), int'(m_z));
      if (done === 1'b1) dut_dones++;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outs(input string tag, input int q, input int r, input int z);
    chk({tag, "_q"}, int'(quotient), q);
    chk({tag, "_r"}, int'(remainder), r);
    chk({tag, "_z"}, int'(div_by_zero), z);
  endtask

  // Start one division from IDLE, scramble the operands afterwards, measure latency.
  task automatic run_div(input int dd, input int dv, input int eq, input int er, input int ez);
    int lat;
    string tag;
    tag = $sformatf("div_%0d_%0d", dd, dv);
    start = 1'b1; dividend = 8'(dd); divisor = 4'(dv);
    cyc();
    start = 1'b0; dividend = ~dividend; divisor = ~divisor;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      cyc();
      lat++;
    end
    chk({tag, "_latency"}, lat, (SHORT && dv == 0) ? 1 : 9);
    check_outs(tag, eq, er, ez);
    cyc();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int lat;
    rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 4'd0;
    cyc(2);
    armed = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    check_outs("rst", 0, 0, 0);
    rst = 1'b0;
    cyc(2);

    run_div(200, 7, 28, 4, 0);
    run_div(255, 15, 17, 0, 0);
    run_div(9, 10, 0, 9, 0);
    run_div(200, 0, 255, 8, 1);
    run_div(0, 1, 0, 0, 0);
    run_div(255, 1, 255, 0, 0);

    // Second start while busy must be ignored.
    d0 = dut_dones;
    start = 1'b1; dividend = 8'd100; divisor = 4'd3;
    cyc();
    start = 1'b0;
    cyc(3);
    start = 1'b1; dividend = 8'd50; divisor = 4'd5;
    cyc();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      cyc();
      lat++;
    end
    check_outs("busy_start", 33, 1, 0);
    cyc(15);
    chk("busy_start_dones", dut_dones - d0, 1);

    // Reset mid-run, with start asserted in the same cycle.
    d0 = dut_dones;
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    cyc();
    start = 1'b0;
    cyc(4);
    rst = 1'b1; start = 1'b1;
    cyc();
    rst = 1'b0; start = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    check_outs("abort", 0, 0, 0);
    cyc(12);
    chk("abort_no_done", dut_dones - d0, 0);
    run_div(13, 4, 3, 1, 0);

    // Exhaustive sweep with start held high.
    d0 = dut_dones;
    start = 1'b1;
    for (int dd = 0; dd < 256; dd++) begin
      for (int dv = 0; dv < 16; dv++) begin
        dividend = 8'(dd); divisor = 4'(dv);
        lat = 0;
        do begin
          cyc();
          lat++;
        end while (done !== 1'b1 && lat < 25);
        if (done !== 1'b1) begin
          chk("sweep_timeout", int'(done), 1);
        end else if (dv != 0) begin
          chk("sweep_identity", int'(quotient) * dv + int'(remainder), dd);
          chk("sweep_rem_lt_div", int'(remainder < 4'(dv)), 1);
          chk("sweep_z", int'(div_by_zero), 0);
        end else begin
          check_outs("sweep_dz", 255, dd % 16, 1);
        end
      end
    end
    start = 1'b0;
    cyc(3);
    chk("sweep_dones", dut_dones - d0, 4096);
    chk("total_dones", dut_dones, exp_dones);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
